// File: rtl/tiny8_cache_pkg.sv
// Shared types for the tiny8 direct-mapped byte cache.
package tiny8_cache_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned NUM_LINES  = 8;
    localparam int unsigned LINE_BYTES = 4;
    localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
    localparam int unsigned INDEX_W    = $clog2(NUM_LINES);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    typedef logic [ADDR_W-1:0] tiny8_word;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } tiny8_cache_addr;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } tiny8_cache_state;

endpackage

// File: rtl/tiny8_cache_array.sv
// Valid/tag/data storage: combinational lookup, synchronous byte write and line (in)validate.
module tiny8_cache_array
    import tiny8_cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                hit_c,
    output tiny8_word           rd_byte_c,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  tiny8_word           wr_byte,
    input  logic                validate,
    input  logic [TAG_W-1:0]    validate_tag,
    input  logic                invalidate
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    tiny8_word            data_mem [NUM_LINES][LINE_BYTES];

    // Lookup for the addressed line.
    always_comb begin
        hit_c     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
        rd_byte_c = data_mem[rd_index][rd_offset];
    end

    // Valid bits are the only reset storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (invalidate) begin
            valid[wr_index] <= 1'b0;
        end else if (validate) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays, no reset.
    always_ff @(posedge clk) begin
        if (validate) begin
            tag_mem[wr_index] <= validate_tag;
        end
        if (wr_en) begin
            data_mem[wr_index][wr_offset] <= wr_byte;
        end
    end

endmodule

// File: rtl/tiny8_cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache for the tiny8 core.
module tiny8_cache
    import tiny8_cache_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      mem_read,
    input  logic      mem_write,
    input  tiny8_word mem_address,
    input  tiny8_word mem_wdata,
    output tiny8_word mem_rdata,
    output logic      mem_resp,
    output logic      pmem_read,
    output logic      pmem_write,
    output tiny8_word pmem_address,
    output tiny8_word pmem_wdata,
    input  tiny8_word pmem_rdata,
    input  logic      pmem_resp
);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(LINE_BYTES - 1);

    tiny8_cache_state    state_q, state_d;
    tiny8_cache_addr     addr_q, addr_d, req, lookup;
    tiny8_word           wdata_q, wdata_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    tiny8_word           rdata_d, paddr_d, pwdata_d;
    logic                resp_d, pread_d, pwrite_d;

    logic                hit_c;
    tiny8_word           rd_byte_c;
    logic                wr_en, validate, invalidate;
    logic [INDEX_W-1:0]  wr_index;
    logic [OFFSET_W-1:0] wr_offset;
    tiny8_word           wr_byte;

    // In IDLE look up the live request, otherwise the latched address.
    always_comb begin
        req    = tiny8_cache_addr'(mem_address);
        lookup = (state_q == IDLE) ? req : addr_q;
    end

    tiny8_cache_array u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (lookup.index),
        .rd_tag       (lookup.tag),
        .rd_offset    (lookup.offset),
        .hit_c        (hit_c),
        .rd_byte_c    (rd_byte_c),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_offset    (wr_offset),
        .wr_byte      (wr_byte),
        .validate     (validate),
        .validate_tag (addr_q.tag),
        .invalidate   (invalidate)
    );

    // Next-state, array control and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = mem_rdata;
        wr_en      = 1'b0;
        wr_index   = addr_q.index;
        wr_offset  = cnt_q;
        wr_byte    = pmem_rdata;
        validate   = 1'b0;
        invalidate = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    addr_d    = req;
                    wdata_d   = mem_wdata;
                    wr_en     = hit_c;
                    wr_index  = req.index;
                    wr_offset = req.offset;
                    wr_byte   = mem_wdata;
                    state_d   = WRITE;
                end else if (mem_read) begin
                    if (hit_c) begin
                        rdata_d = rd_byte_c;
                        state_d = RESP;
                    end else begin
                        addr_d     = req;
                        cnt_d      = '0;
                        invalidate = 1'b1;
                        wr_index   = req.index;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_OFFSET) begin
                        validate = 1'b1;
                        // The requested byte may be arriving right now.
                        rdata_d  = (addr_q.offset == cnt_q) ? pmem_rdata : rd_byte_c;
                        state_d  = RESP;
                    end else begin
                        cnt_d = cnt_q + OFFSET_W'(1);
                    end
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_d   = (state_d == RESP);
        pread_d  = (state_d == FILL);
        pwrite_d = (state_d == WRITE);
        paddr_d  = '0;
        pwdata_d = '0;
        if (state_d == FILL) begin
            paddr_d = tiny8_word'({addr_d.tag, addr_d.index, cnt_d});
        end else if (state_d == WRITE) begin
            paddr_d  = tiny8_word'(addr_d);
            pwdata_d = wdata_d;
        end
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_rdata    <= '0;
            mem_resp     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_rdata    <= rdata_d;
            mem_resp     <= resp_d;
            pmem_read    <= pread_d;
            pmem_write   <= pwrite_d;
            pmem_address <= paddr_d;
            pmem_wdata   <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_tiny8_cache.sv
// Scoreboard bench for tiny8_cache with a 2-cycle physical memory model.
module tb_tiny8_cache;
    import tiny8_cache_pkg::*;

    typedef struct packed {
        logic      w;
        tiny8_word a;
        tiny8_word d;
    } op_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      mem_read = 1'b0;
    logic      mem_write = 1'b0;
    tiny8_word mem_address = '0;
    tiny8_word mem_wdata = '0;
    tiny8_word mem_rdata;
    logic      mem_resp;
    logic      pmem_read;
    logic      pmem_write;
    tiny8_word pmem_address;
    tiny8_word pmem_wdata;
    tiny8_word pmem_rdata = '0;
    logic      pmem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    op_t       exp_ops[$];
    op_t       obs_ops[$];
    tiny8_word exp_rdata[$];

    tiny8_word pm [256];
    bit        pm_wr [256];
    int        model_cnt = 0;
    int        resp_count = 0;

    tiny8_cache dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Physical memory: byte = addr ^ 0xA5 unless written, answers on the second cycle of a request.
    always @(negedge clk) begin
        if (rst) begin
            pmem_resp = 1'b0;
            model_cnt = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            model_cnt = 0;
        end else if (pmem_read || pmem_write) begin
            model_cnt++;
            if (model_cnt == 2) begin
                obs_ops.push_back({pmem_write, pmem_address, pmem_write ? pmem_wdata : 8'h00});
                if (pmem_write) begin
                    pm[pmem_address]    = pmem_wdata;
                    pm_wr[pmem_address] = 1'b1;
                end else begin
                    pmem_rdata = pm_wr[pmem_address] ? pm[pmem_address] : (pmem_address ^ 8'hA5);
                end
                pmem_resp = 1'b1;
                resp_count++;
            end
        end
    end

    task automatic check_ops(input string name);
        op_t e, o;
        while (exp_ops.size() > 0) begin
            e = exp_ops.pop_front();
            checks++;
            if (obs_ops.size() == 0) begin
                errors++;
                $display("FAIL %s pmem_op missing: got none, want w=%0b addr=%02h data=%02h", name, e.w, e.a, e.d);
            end else begin
                o = obs_ops.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s pmem_op: got w=%0b addr=%02h data=%02h, want w=%0b addr=%02h data=%02h",
                             name, o.w, o.a, o.d, e.w, e.a, e.d);
                end
            end
        end
        checks++;
        if (obs_ops.size() != 0) begin
            errors++;
            $display("FAIL %s pmem_extra: got %0d extra ops, want 0", name, obs_ops.size());
        end
        obs_ops.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got resp=%0b rdata=%02h pr=%0b pw=%0b pa=%02h pd=%02h, want all 0",
                     name, mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata);
        end
    endtask

    task automatic read_req(input tiny8_word addr, input tiny8_word exp, input bit hit, input string name);
        int        lat;
        tiny8_word e;
        if (!hit) begin
            for (int i = 0; i < 4; i++) begin
                exp_ops.push_back({1'b0, (addr & 8'hFC) | tiny8_word'(i), 8'h00});
            end
        end
        exp_rdata.push_back(exp);
        @(negedge clk);
        mem_address = addr;
        mem_read    = 1'b1;
        lat         = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_resp && lat < 60);
        mem_read = 1'b0;
        e = exp_rdata.pop_front();
        checks++;
        if (!mem_resp) begin
            errors++;
            $display("FAIL %s timeout: got no mem_resp in %0d cycles, want one", name, lat);
        end else if (mem_rdata !== e) begin
            errors++;
            $display("FAIL %s rdata: got %02h, want %02h", name, mem_rdata, e);
        end
        if (hit) begin
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL %s hit_latency: got %0d, want 1", name, lat);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_pulse: got %0b one cycle later, want 0", name, mem_resp);
        end
        check_ops(name);
    endtask

    task automatic write_req(input tiny8_word addr, input tiny8_word data, input string name);
        int lat;
        exp_ops.push_back({1'b1, addr, data});
        @(negedge clk);
        mem_address = addr;
        mem_wdata   = data;
        mem_write   = 1'b1;
        lat         = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_resp && lat < 60);
        mem_write = 1'b0;
        checks++;
        if (!mem_resp) begin
            errors++;
            $display("FAIL %s timeout: got no mem_resp in %0d cycles, want one", name, lat);
        end
        @(negedge clk);
        check_ops(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        read_req(8'h25, 8'h80, 1'b0, "cold_miss");
    endtask

    task automatic test_read_hit();
        read_req(8'h27, 8'h82, 1'b1, "read_hit");
    endtask

    task automatic test_write_hit();
        write_req(8'h26, 8'h5A, "write_hit");
        read_req(8'h26, 8'h5A, 1'b1, "write_hit_read");
    endtask

    task automatic test_write_miss();
        write_req(8'h80, 8'h11, "write_miss");
        read_req(8'h80, 8'h11, 1'b0, "write_miss_read");
    endtask

    task automatic test_conflict();
        read_req(8'hA5, 8'h00, 1'b0, "conflict_evict");
        read_req(8'h25, 8'h80, 1'b0, "conflict_refill");
    endtask

    task automatic test_back_to_back();
        read_req(8'h24, 8'h81, 1'b1, "b2b_0");
        read_req(8'h26, 8'h5A, 1'b1, "b2b_1");
        read_req(8'h83, 8'h26, 1'b1, "b2b_2");
    endtask

    task automatic test_reset_mid_fill();
        int base;
        int waited;
        base = resp_count;
        exp_ops.push_back({1'b0, 8'h44, 8'h00});
        exp_ops.push_back({1'b0, 8'h45, 8'h00});
        @(negedge clk);
        mem_address = 8'h45;
        mem_read    = 1'b1;
        waited      = 0;
        while (resp_count < base + 2 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (resp_count < base + 2) begin
            errors++;
            $display("FAIL mid_fill timeout: got %0d fill bytes, want 2", resp_count - base);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        check_idle_outputs("mid_fill_reset");
        @(negedge clk);
        rst = 1'b0;
        check_ops("mid_fill_partial");
        read_req(8'h25, 8'h80, 1'b0, "after_reset_fill");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_back_to_back();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
